// File: rtl/mult_hilo_unit.sv
// MULT/MULTU front end with HI/LO registers. It drives an iterative 32x32 Karatsuba core
// that is built from 16-bit halves and owned by the sequencing FSM.

module iterative_karatsuba_32_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] c
);
   localparam int unsigned STEP_W = 3;

   logic [STEP_W-1:0] step_q, step_d;
   logic [31:0]       z0_q, z0_d, z2_q, z2_d;
   logic [33:0]       zm_q, zm_d;
   logic [63:0]       c_q, c_d;

   // One partial product per enabled cycle; the product is final after four steps.
   always_comb begin
      step_d = step_q;
      z0_d   = z0_q;
      z2_d   = z2_q;
      zm_d   = zm_q;
      c_d    = c_q;
      if (en) begin
         case (step_q)
            3'd0: z0_d = 32'(a[15:0]) * 32'(b[15:0]);
            3'd1: z2_d = 32'(a[31:16]) * 32'(b[31:16]);
            3'd2: zm_d = (34'(a[15:0]) + 34'(a[31:16])) * (34'(b[15:0]) + 34'(b[31:16]));
            3'd3: c_d  = {z2_q, z0_q} + ((64'(zm_q) - 64'(z0_q) - 64'(z2_q)) << 16);
            default: ;
         endcase
         if (step_q != 3'd4) step_d = step_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_q <= '0;
         z0_q   <= '0;
         z2_q   <= '0;
         zm_q   <= '0;
         c_q    <= '0;
      end else begin
         step_q <= step_d;
         z0_q   <= z0_d;
         z2_q   <= z2_d;
         zm_q   <= zm_d;
         c_q    <= c_d;
      end
   end

   assign c = c_q;
endmodule

module mult_hilo_unit #(
   parameter int unsigned MUL_LAT = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);
   localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_FIX} state_t;

   state_t            state_q, state_d;
   logic [31:0]       ma_q, ma_d, mb_q, mb_d;
   logic              neg_q, neg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       hi_q, hi_d, lo_q, lo_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [63:0]       prod;
   logic [63:0]       res;
   logic              core_rst_c, core_en_c;

   assign core_rst_c = rst | (state_q == S_CLR);
   assign core_en_c  = (state_q == S_RUN);

   iterative_karatsuba_32_16 u_core (
      .clk (clk),
      .rst (core_rst_c),
      .en  (core_en_c),
      .a   (ma_q),
      .b   (mb_q),
      .c   (prod)
   );

   // Sequencing, operand conversion, sign correction and MTHI/MTLO writes.
   always_comb begin
      state_d = state_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      res     = neg_q ? (~prod + 64'd1) : prod;
      case (state_q)
         S_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               ma_d    = (op_signed && a[31]) ? (~a + 32'd1) : a;
               mb_d    = (op_signed && b[31]) ? (~b + 32'd1) : b;
               neg_d   = op_signed & (a[31] ^ b[31]);
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            cnt_d   = CNT_W'(MUL_LAT);
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            hi_d    = res[63:32];
            lo_d    = res[31:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ma_q    <= '0;
         mb_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: doc/mult_hilo_unit.md
# mult_hilo_unit

Signed/unsigned 32×32 multiply front end for the MIPS datapath, implementing MULT/MULTU, MTHI/MTLO and the HI/LO register pair. It captures operands on a start handshake, converts signed operands to magnitudes and drives the iterative_karatsuba_32_16 core. The core is instantiated inside this block and owned by its FSM. The block sign-corrects the 64-bit unsigned product and writes HI/LO, with busy/done status back to the pipeline control.

## Interface

Parameters:
- MUL_LAT, default 6: cycles the core enable is held high before its product is sampled; must be ≥ 5.

Ports:
- clk: input, 1 bit, clock.
- rst: input, 1 bit, reset. Synchronous, active-high.
- start: input, 1 bit, request a multiply. Accepted only when busy=0.
- op_signed: input, 1 bit, 1 = MULT (two's complement), 0 = MULTU. Sampled with start.
- a: input, 32 bits, operand rs. Sampled with start.
- b: input, 32 bits, operand rt. Sampled with start.
- hi_we: input, 1 bit, MTHI write enable.
- lo_we: input, 1 bit, MTLO write enable.
- wdata: input, 32 bits, MTHI/MTLO data.
- hi: output, 32 bits, HI register.
- lo: output, 32 bits, LO register.
- busy: output, 1 bit, multiply in flight.
- done: output, 1 bit, one-cycle pulse when HI/LO have just been written with a product.

## Operation

- Internal registers:
  - ma, mb: 32-bit operand magnitudes.
  - neg: 1-bit result sign.
  - cnt: down-counter, width clog2(MUL_LAT+1).
  - hi, lo.
  - FSM state.
- Operand conversion on accept:
  - If op_signed=1, ma = a[31] ? −a : a. mb is formed the same way from b.
  - If op_signed=1, neg = a[31] ^ b[31].
  - If op_signed=0, ma = a, mb = b, neg = 0.
  - 0x80000000 converts to magnitude 0x80000000, which is exact in 32-bit unsigned.
- Core hookup: ma→A, mb→B, core C→product P[63:0].
  - Core rst is driven only in CLR or when block rst=1.
  - Core enable is driven only in RUN.
- FSM states:
  - IDLE: busy=0. If start=1: capture ma, mb, neg and go to CLR.
  - CLR: core reset high for one cycle. Load cnt=MUL_LAT, go to RUN.
  - RUN: core enable high, decrement cnt. When cnt=1, go to FIX.
  - FIX: R = neg ? (~P + 1) : P, computed mod 2^64. Write hi=R[63:32] and lo=R[31:0]. Set done=1 for the next cycle. Go to IDLE.
- MTHI/MTLO:
  - In IDLE, hi_we writes wdata to hi and lo_we writes wdata to lo, at the clock edge.
  - While busy=1, hi_we and lo_we are ignored with no effect.
  - hi_we, lo_we and start may be asserted together in IDLE. The writes complete, the start is accepted, and the product later overwrites both registers.
- A start while busy=1 is ignored and not queued.
- Zero operands need no special case: magnitude 0 gives P=0, and negating 0 gives 0.

## Timing

- Reset (rst=1 at an edge):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, cnt=0, ma=mb=0, neg=0.
  - Core is held in reset.
  - rst takes priority over every other input, including mid-operation in any state. The in-flight multiply is discarded and no done pulse is produced.
- Accept and busy:
  - Start is accepted at edge E0 when state=IDLE and start=1.
  - busy=1 from E0 until edge E0+MUL_LAT+2.
  - busy is a registered output, equal to (state≠IDLE).
- Result:
  - HI/LO are updated at edge E0+MUL_LAT+2.
  - done=1 for exactly the cycle following that edge, coincident with busy=0.
  - Total latency from accept to result visible is MUL_LAT+2 cycles; with the default that is 8.
- Back-to-back: a new start may be accepted on the same cycle that done=1, i.e. at edge E0+MUL_LAT+3.
- Reading: hi and lo are plain register outputs, readable any cycle. During busy they hold their previous values.

## Test plan

- Unsigned max: op_signed=0, a=b=0xFFFFFFFF.
  - At +8 cycles, hi=0xFFFFFFFE and lo=0x00000001.
  - done pulses exactly once.
- Signed mixed signs: op_signed=1.
  - a=0xFFFFFFFF, b=0x00000001 → hi=0xFFFFFFFF, lo=0xFFFFFFFF.
  - a=0xFFFFFFFD (−3), b=0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Signed most-negative: op_signed=1, a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
  - Same operands with op_signed=0 → hi=0x40000000, lo=0x00000000.
- Start while busy:
  - Start 3×4, then re-assert start with 5×6 two cycles later.
  - Result is hi=0, lo=12, with one done pulse.
  - The hi_we asserted during busy has no effect.
- Reset mid-operation:
  - Start 0x10000×0x10000, then assert rst at +4 cycles.
  - hi=lo=0, busy=0, and no done pulse afterwards.
  - A following 2×3 multiply gives lo=6.
- MTHI/MTLO with simultaneous start:
  - In IDLE, hi_we=1 with wdata=0xDEADBEEF → hi=0xDEADBEEF the next cycle.
  - Then hi_we=1 and start(7×9) on the same cycle: hi=wdata immediately, then hi=0 and lo=63 at +8 cycles.
